// File: rtl/arb_mux2x1.sv
// Two-input valid/ready arbiter with a registered output slot.
// Ties go to the current owner until its burst budget is spent, then switch.
//
// Ports:
//   clk, rst            : clock, async active-high reset
//   inX_valid/data/ready: requester X handshake (X = 0,1)
//   out_valid/ready/data: registered output handshake
//   out_src             : requester index that supplied out_data
module arb_mux2x1 #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             src_q;

  logic load;
  logic gnt0, gnt1;
  logic xfer0, xfer1;
  logic burst_left;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output logic: grants and readies
  always_comb begin
    load       = !valid_q || out_ready;
    burst_left = (cnt_q < CMAX);
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    if (in0_valid && !in1_valid) begin
      gnt0 = 1'b1;
    end else if (in1_valid && !in0_valid) begin
      gnt1 = 1'b1;
    end else if (in0_valid && in1_valid) begin
      case (state_q)
        OWN0: begin
          gnt0 = burst_left;
          gnt1 = !burst_left;
        end
        OWN1: begin
          gnt1 = burst_left;
          gnt0 = !burst_left;
        end
        default: gnt0 = 1'b1;
      endcase
    end
    // Readies drop during reset so no word is taken while state is forced.
    in0_ready = load && gnt0 && !rst;
    in1_ready = load && gnt1 && !rst;
    xfer0     = in0_valid && in0_ready;
    xfer1     = in1_valid && in1_ready;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load) begin
      if (xfer0) begin
        state_d = OWN0;
        if (state_q != OWN0) cnt_d = CW'(1);
        else if (burst_left) cnt_d = cnt_q + CW'(1);
      end else if (xfer1) begin
        state_d = OWN1;
        if (state_q != OWN1) cnt_d = CW'(1);
        else if (burst_left) cnt_d = cnt_q + CW'(1);
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Output slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= 1'b0;
    end else if (load) begin
      valid_q <= xfer0 || xfer1;
      if (xfer0) begin
        data_q <= in0_data;
        src_q  <= 1'b0;
      end else if (xfer1) begin
        data_q <= in1_data;
        src_q  <= 1'b1;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_arb_mux2x1.sv
// Directed bench for arb_mux2x1 (MAX_BURST=2).
// Inputs change #1 after posedge; outputs checked before the next edge.
module tb_arb_mux2x1;

  logic       clk = 1'b0;
  logic       rst;
  logic       in0_valid, in1_valid;
  logic [7:0] in0_data, in1_data;
  logic       in0_ready, in1_ready;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_src;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arb_mux2x1 #(.WIDTH(8), .MAX_BURST(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 8'h00;
    in1_data  = 8'h00;
    out_ready = 1'b1;
    #1;
    chk("rst_rdy0", in0_ready, 0);
    chk("rst_rdy1", in1_ready, 0);
    chk("rst_oval", out_valid, 0);
    chk("rst_odat", out_data, 8'h00);
    chk("rst_osrc", out_src, 0);

    tick();
    tick();
    rst       = 1'b0;
    in1_valid = 1'b0;
    in0_data  = 8'hA5;
    #1;
    chk("s_rdy0", in0_ready, 1);
    chk("s_rdy1", in1_ready, 0);
    tick();
    chk("s_oval1", out_valid, 1);
    chk("s_odat1", out_data, 8'hA5);
    chk("s_osrc1", out_src, 0);
    in0_data = 8'h3C;
    #1;
    chk("s_rdy1b", in1_ready, 0);
    tick();
    chk("s_odat2", out_data, 8'h3C);
    chk("s_osrc2", out_src, 0);
    in0_valid = 1'b0;
    tick();
    chk("s_drain", out_valid, 0);
    chk("s_hold", out_data, 8'h3C);

    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 8'h10;
    in1_data  = 8'h20;
    begin
      logic [5:0] seq;
      seq = 6'b001100;
      for (int i = 0; i < 6; i++) begin
        tick();
        chk($sformatf("tie_src%0d", i), out_src, seq[5-i]);
        chk($sformatf("tie_dat%0d", i), out_data,
            seq[5-i] ? 8'h20 : 8'h10);
      end
    end

    in1_valid = 1'b0;
    in0_data  = 8'h5A;
    tick();
    chk("bp_load", out_data, 8'h5A);
    out_ready = 1'b0;
    in1_valid = 1'b1;
    in0_data  = 8'h11;
    in1_data  = 8'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_r0_%0d", i), in0_ready, 0);
      chk($sformatf("bp_r1_%0d", i), in1_ready, 0);
      tick();
      chk($sformatf("bp_dat%0d", i), out_data, 8'h5A);
      chk($sformatf("bp_val%0d", i), out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_r1", in1_ready, 1);
    tick();
    chk("bp_next", out_data, 8'h77);
    chk("bp_nsrc", out_src, 1);

    in1_valid = 1'b0;
    in0_data  = 8'h01;
    tick();
    chk("od_own0", out_src, 0);
    in0_valid = 1'b0;
    in1_valid = 1'b1;
    in1_data  = 8'h02;
    #1;
    chk("od_rdy1", in1_ready, 1);
    tick();
    chk("od_src1", out_src, 1);
    chk("od_dat1", out_data, 8'h02);
    in0_valid = 1'b1;
    in0_data  = 8'h03;
    in1_data  = 8'h04;
    #1;
    chk("od_tie_r1", in1_ready, 1);
    chk("od_tie_r0", in0_ready, 0);

    #1;
    rst = 1'b1;
    #1;
    chk("ar_oval", out_valid, 0);
    chk("ar_odat", out_data, 8'h00);
    chk("ar_osrc", out_src, 0);
    chk("ar_rdy0", in0_ready, 0);
    chk("ar_rdy1", in1_ready, 0);
    rst = 1'b0;
    #1;
    chk("ar_tie_r0", in0_ready, 1);
    chk("ar_tie_r1", in1_ready, 0);
    tick();
    chk("ar_src", out_src, 0);
    chk("ar_dat", out_data, 8'h03);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
